row_stream_loader: RTL and testbench

//  Synthesizable image/CNN-data loader that replaces bench-side file feeding.

---
 rtl/row_stream_loader.sv | 164 ++++++++++++++++
 tb/tb_row_stream_loader.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/row_stream_loader.sv
// Row/CNN-word loader: buffers host rows in a small FIFO, releases one per send edge, then streams CNN words.
// Optional interrupt output enabled by defining ROW_STREAM_LOADER_IRQ_EN (otherwise irq is tied low).
module row_stream_loader #(
  parameter int ROW_W      = 480,
  parameter int DATA_W     = 16,
  parameter int NUM_ROWS   = 29,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ROW_W-1:0]  host_row,
  input  logic              host_row_valid,
  output logic              host_row_ready,
  input  logic [DATA_W-1:0] host_data,
  input  logic              host_data_valid,
  input  logic              host_data_last,
  output logic              host_data_ready,
  input  logic              send,
  input  logic              stop,
  output logic [ROW_W-1:0]  row_out,
  output logic              row_valid,
  output logic [DATA_W-1:0] cnn_data,
  output logic              cnn_data_valid,
  output logic              load_process,
  output logic              cnn_image,
  output logic [CNT_W-1:0]  rows_loaded,
  output logic              done,
  output logic              irq
);

  localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CNT_W-1:0] ROWS_MAX = CNT_W'(NUM_ROWS);
  localparam logic [AW:0]      DEPTH_C  = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]      CNT_ONE  = 1;
  localparam logic [AW-1:0]    PTR_ONE  = 1;

  typedef enum logic [1:0] {IDLE, ROWS, DATA, DONE} state_t;

  state_t           state;
  logic [ROW_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic [CNT_W-1:0] pushed;
  logic             send_q, pending;
  logic             send_edge, push, pop, accept, full, empty;
  logic             start_ok, last_pop, last_word;

  assign full            = (count == DEPTH_C);
  assign empty           = (count == '0);
  assign send_edge       = send & ~send_q;
  assign host_row_ready  = (state == ROWS) && !full && (pushed < ROWS_MAX);
  assign push            = host_row_valid && host_row_ready;
  // A fresh edge or an outstanding request is served only when a row is available and not frozen.
  assign pop             = (state == ROWS) && !stop && !empty && (send_edge || pending);
  assign host_data_ready = (state == DATA) && !stop;
  assign accept          = host_data_valid && host_data_ready;
  assign start_ok        = start && ((state == IDLE) || (state == DONE));
  assign last_pop        = pop && ((rows_loaded + CNT_W'(1)) == ROWS_MAX);
  assign last_word       = accept && host_data_last;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= host_row;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      pushed         <= '0;
      send_q         <= 1'b0;
      pending        <= 1'b0;
      row_out        <= '0;
      row_valid      <= 1'b0;
      cnn_data       <= '0;
      cnn_data_valid <= 1'b0;
      load_process   <= 1'b0;
      cnn_image      <= 1'b0;
      rows_loaded    <= '0;
      done           <= 1'b0;
    end else begin
      send_q         <= send;
      row_valid      <= 1'b0;
      cnn_data_valid <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start_ok) begin
            state        <= ROWS;
            load_process <= 1'b1;
            cnn_image    <= 1'b0;
            done         <= 1'b0;
            rows_loaded  <= '0;
            pushed       <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            pending      <= 1'b0;
          end
        end
        ROWS: begin
          if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
            pushed <= pushed + CNT_W'(1);
          end
          if (pop) begin
            rd_ptr      <= rd_ptr + PTR_ONE;
            row_out     <= mem[rd_ptr];
            row_valid   <= 1'b1;
            rows_loaded <= rows_loaded + CNT_W'(1);
            pending     <= 1'b0;
            if (last_pop) begin
              state     <= DATA;
              cnn_image <= 1'b1;
            end
          end else if (send_edge) begin
            pending <= 1'b1;
          end
          if (push && !pop) count <= count + CNT_ONE;
          else if (pop && !push) count <= count - CNT_ONE;
        end
        DATA: begin
          if (accept) begin
            cnn_data       <= host_data;
            cnn_data_valid <= 1'b1;
            if (host_data_last) begin
              state        <= DONE;
              load_process <= 1'b0;
              cnn_image    <= 1'b0;
              done         <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ROW_STREAM_LOADER_IRQ_EN
  // Saturates at 256 so a stuck request raises exactly one timeout pulse.
  logic [8:0] wait_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq      <= 1'b0;
      wait_cnt <= '0;
    end else begin
      irq <= 1'b0;
      if (last_pop || last_word) irq <= 1'b1;
      if (start_ok || pop || (state != ROWS) || !pending) begin
        wait_cnt <= '0;
      end else if (wait_cnt != 9'd256) begin
        wait_cnt <= wait_cnt + 9'd1;
        if (wait_cnt == 9'd255) irq <= 1'b1;
      end
    end
  end
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_row_stream_loader.sv
// Self-checking bench for row_stream_loader: directed vector table, hand sequences and a randomized queue-based model.
module tb_row_stream_loader;
  localparam int ROW_W = 8, DATA_W = 8, NUM_ROWS = 3, FIFO_DEPTH = 2, CNT_W = 16;
`ifdef ROW_STREAM_LOADER_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic [ROW_W-1:0] host_row = '0;
  logic host_row_valid = 1'b0, host_row_ready;
  logic [DATA_W-1:0] host_data = '0;
  logic host_data_valid = 1'b0, host_data_last = 1'b0, host_data_ready;
  logic send = 1'b0, stop = 1'b0;
  logic [ROW_W-1:0] row_out;
  logic row_valid;
  logic [DATA_W-1:0] cnn_data;
  logic cnn_data_valid, load_process, cnn_image, done, irq;
  logic [CNT_W-1:0] rows_loaded;

  always #5 clk = ~clk;

  row_stream_loader #(.ROW_W(ROW_W), .DATA_W(DATA_W), .NUM_ROWS(NUM_ROWS),
                      .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .host_row(host_row), .host_row_valid(host_row_valid), .host_row_ready(host_row_ready),
    .host_data(host_data), .host_data_valid(host_data_valid), .host_data_last(host_data_last),
    .host_data_ready(host_data_ready), .send(send), .stop(stop),
    .row_out(row_out), .row_valid(row_valid), .cnn_data(cnn_data), .cnn_data_valid(cnn_data_valid),
    .load_process(load_process), .cnn_image(cnn_image), .rows_loaded(rows_loaded),
    .done(done), .irq(irq)
  );

  int n_checks = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic st, rv; logic [7:0] r; logic sd, sp, dv; logic [7:0] d; logic dl;
    logic rr, dr, rvld; logic [7:0] rout; logic [15:0] rl; logic ci, lp, dn, cv; logic [7:0] cd;
  } vec_t;
  vec_t vt[28];

  function automatic vec_t mk(logic st, logic rv, logic [7:0] r, logic sd, logic sp, logic dv,
                              logic [7:0] d, logic dl, logic rr, logic dr, logic rvld,
                              logic [7:0] rout, logic [15:0] rl, logic ci, logic lp, logic dn,
                              logic cv, logic [7:0] cd);
    vec_t v;
    v.st = st; v.rv = rv; v.r = r; v.sd = sd; v.sp = sp; v.dv = dv; v.d = d; v.dl = dl;
    v.rr = rr; v.dr = dr; v.rvld = rvld; v.rout = rout; v.rl = rl; v.ci = ci; v.lp = lp;
    v.dn = dn; v.cv = cv; v.cd = cd;
    return v;
  endfunction

  // Behavioural model: queue for the row FIFO, integer phase 0 idle / 1 rows / 2 data / 3 done.
  int phase, m_pushed, m_age;
  logic [7:0] mq[$];
  bit m_pend, m_prev_send, m_rvld, m_cv, m_ci, m_lp, m_dn, m_irq, m_rr, m_dr;
  logic [7:0] m_rout, m_cd;
  logic [15:0] m_rl;

  task automatic model_reset();
    phase = 0; mq.delete(); m_pushed = 0; m_age = 0; m_pend = 0; m_prev_send = 0;
    m_rvld = 0; m_cv = 0; m_ci = 0; m_lp = 0; m_dn = 0; m_irq = 0; m_rout = 0; m_cd = 0; m_rl = 0;
  endtask

  task automatic model_step();
    bit edge_s, served;
    m_rr = (phase == 1) && (mq.size() < FIFO_DEPTH) && (m_pushed < NUM_ROWS);
    m_dr = (phase == 2) && !stop;
    edge_s = send && !m_prev_send;
    m_prev_send = send;
    m_rvld = 0; m_cv = 0; m_irq = 0;
    case (phase)
      0, 3: if (start) begin
        phase = 1; m_lp = 1; m_ci = 0; m_dn = 0; m_rl = 0; m_pushed = 0;
        mq.delete(); m_pend = 0; m_age = 0;
      end
      1: begin
        served = (edge_s || m_pend) && !stop && (mq.size() > 0);
        if (served) begin
          m_rout = mq.pop_front(); m_rvld = 1; m_rl++; m_pend = 0; m_age = 0;
          if (m_rl == NUM_ROWS) begin phase = 2; m_ci = 1; m_irq = 1; end
        end else if (m_pend) begin
          m_age++;
          if (m_age == 256) m_irq = 1;
        end else if (edge_s) begin
          m_pend = 1; m_age = 0;
        end
        if (host_row_valid && m_rr) begin mq.push_back(host_row); m_pushed++; end
      end
      2: if (host_data_valid && !stop) begin
        m_cd = host_data; m_cv = 1;
        if (host_data_last) begin phase = 3; m_lp = 0; m_ci = 0; m_dn = 1; end
      end
      default: ;
    endcase
    m_irq = m_irq && IRQ_EN;
  endtask

  task automatic idle_inputs();
    start = 0; host_row_valid = 0; host_row = '0; host_data_valid = 0; host_data = '0;
    host_data_last = 0; send = 0; stop = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1;
    @(posedge clk); #1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  int irq_cnt;

  initial begin
    // ---------------- reset state ----------------
    idle_inputs();
    #1;
    check("reset row_ready", host_row_ready, 0);
    check("reset data_ready", host_data_ready, 0);
    check("reset row_valid", row_valid, 0);
    check("reset load_process", load_process, 0);
    check("reset done", done, 0);
    check("reset irq", irq, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1;
    tick();
    check("idle row_ready", host_row_ready, 0);
    check("idle rows_loaded", rows_loaded, 0);

    // ---------------- directed vector table ----------------
    //             st rv r     sd sp dv d     dl  rr dr rvld rout  rl ci lp dn cv cd
    vt[0]  = mk(1, 0, 8'h00, 0, 0, 0, 8'h00, 0,  0, 0, 0, 8'h00, 0, 0, 1, 0, 0, 8'h00);
    vt[1]  = mk(0, 1, 8'hA1, 0, 0, 0, 8'h00, 0,  1, 0, 0, 8'h00, 0, 0, 1, 0, 0, 8'h00);
    vt[2]  = mk(0, 1, 8'hA2, 0, 0, 0, 8'h00, 0,  1, 0, 0, 8'h00, 0, 0, 1, 0, 0, 8'h00);
    vt[3]  = mk(0, 1, 8'hA3, 0, 0, 0, 8'h00, 0,  0, 0, 0, 8'h00, 0, 0, 1, 0, 0, 8'h00);
    vt[4]  = mk(0, 1, 8'hA3, 1, 0, 0, 8'h00, 0,  0, 0, 1, 8'hA1, 1, 0, 1, 0, 0, 8'h00);
    vt[5]  = mk(0, 1, 8'hA3, 0, 0, 0, 8'h00, 0,  1, 0, 0, 8'hA1, 1, 0, 1, 0, 0, 8'h00);
    vt[6]  = mk(0, 0, 8'h00, 1, 0, 0, 8'h00, 0,  0, 0, 1, 8'hA2, 2, 0, 1, 0, 0, 8'h00);
    vt[7]  = mk(0, 0, 8'h00, 0, 0, 0, 8'h00, 0,  0, 0, 0, 8'hA2, 2, 0, 1, 0, 0, 8'h00);
    vt[8]  = mk(0, 0, 8'h00, 1, 0, 0, 8'h00, 0,  0, 0, 1, 8'hA3, 3, 1, 1, 0, 0, 8'h00);
    vt[9]  = mk(0, 0, 8'h00, 0, 1, 1, 8'h11, 0,  0, 0, 0, 8'hA3, 3, 1, 1, 0, 0, 8'h00);
    vt[10] = mk(0, 0, 8'h00, 0, 0, 1, 8'h11, 0,  0, 1, 0, 8'hA3, 3, 1, 1, 0, 1, 8'h11);
    vt[11] = mk(0, 0, 8'h00, 0, 0, 1, 8'h22, 0,  0, 1, 0, 8'hA3, 3, 1, 1, 0, 1, 8'h22);
    vt[12] = mk(0, 0, 8'h00, 1, 0, 1, 8'h33, 1,  0, 1, 0, 8'hA3, 3, 0, 0, 1, 1, 8'h33);
    vt[13] = mk(0, 0, 8'h00, 0, 0, 1, 8'h44, 0,  0, 0, 0, 8'hA3, 3, 0, 0, 1, 0, 8'h33);
    vt[14] = mk(1, 0, 8'h00, 0, 0, 0, 8'h00, 0,  0, 0, 0, 8'hA3, 0, 0, 1, 0, 0, 8'h33);
    vt[15] = mk(0, 0, 8'h00, 1, 0, 0, 8'h00, 0,  1, 0, 0, 8'hA3, 0, 0, 1, 0, 0, 8'h33);
    vt[16] = mk(0, 0, 8'h00, 0, 0, 0, 8'h00, 0,  1, 0, 0, 8'hA3, 0, 0, 1, 0, 0, 8'h33);
    vt[17] = mk(0, 0, 8'h00, 1, 0, 0, 8'h00, 0,  1, 0, 0, 8'hA3, 0, 0, 1, 0, 0, 8'h33);
    vt[18] = mk(0, 1, 8'h5C, 0, 0, 0, 8'h00, 0,  1, 0, 0, 8'hA3, 0, 0, 1, 0, 0, 8'h33);
    vt[19] = mk(0, 1, 8'h6D, 0, 0, 0, 8'h00, 0,  1, 0, 1, 8'h5C, 1, 0, 1, 0, 0, 8'h33);
    vt[20] = mk(1, 0, 8'h00, 0, 0, 0, 8'h00, 0,  1, 0, 0, 8'h5C, 1, 0, 1, 0, 0, 8'h33);
    vt[21] = mk(0, 0, 8'h00, 1, 1, 0, 8'h00, 0,  1, 0, 0, 8'h5C, 1, 0, 1, 0, 0, 8'h33);
    vt[22] = mk(0, 0, 8'h00, 1, 0, 0, 8'h00, 0,  1, 0, 1, 8'h6D, 2, 0, 1, 0, 0, 8'h33);
    vt[23] = mk(0, 1, 8'h7E, 0, 0, 0, 8'h00, 0,  1, 0, 0, 8'h6D, 2, 0, 1, 0, 0, 8'h33);
    vt[24] = mk(0, 0, 8'h00, 1, 0, 0, 8'h00, 0,  0, 0, 1, 8'h7E, 3, 1, 1, 0, 0, 8'h33);
    vt[25] = mk(0, 0, 8'h00, 0, 1, 1, 8'h99, 0,  0, 0, 0, 8'h7E, 3, 1, 1, 0, 0, 8'h33);
    vt[26] = mk(0, 0, 8'h00, 0, 0, 1, 8'hA5, 1,  0, 1, 0, 8'h7E, 3, 0, 0, 1, 1, 8'hA5);
    vt[27] = mk(0, 0, 8'h00, 0, 0, 0, 8'h00, 0,  0, 0, 0, 8'h7E, 3, 0, 0, 1, 0, 8'hA5);

    for (int i = 0; i < 28; i++) begin
      start = vt[i].st; host_row_valid = vt[i].rv; host_row = vt[i].r; send = vt[i].sd;
      stop = vt[i].sp; host_data_valid = vt[i].dv; host_data = vt[i].d; host_data_last = vt[i].dl;
      #1;
      check($sformatf("v%0d row_ready", i), host_row_ready, vt[i].rr);
      check($sformatf("v%0d data_ready", i), host_data_ready, vt[i].dr);
      tick();
      check($sformatf("v%0d row_valid", i), row_valid, vt[i].rvld);
      check($sformatf("v%0d row_out", i), row_out, vt[i].rout);
      check($sformatf("v%0d rows_loaded", i), rows_loaded, vt[i].rl);
      check($sformatf("v%0d cnn_image", i), cnn_image, vt[i].ci);
      check($sformatf("v%0d load_process", i), load_process, vt[i].lp);
      check($sformatf("v%0d done", i), done, vt[i].dn);
      check($sformatf("v%0d cnn_valid", i), cnn_data_valid, vt[i].cv);
      check($sformatf("v%0d cnn_data", i), cnn_data, vt[i].cd);
    end
    idle_inputs();
    $display("table: %0d vectors applied", 28);

    // ---------------- reset in the middle of a load ----------------
    start = 1; tick(); start = 0;
    host_row_valid = 1; host_row = 8'h42; tick();
    host_row = 8'h43; tick();
    host_row_valid = 0; send = 1; tick();
    check("mid pre-reset row_valid", row_valid, 1);
    check("mid pre-reset row_out", row_out, 8'h42);
    #2 rst = 0;
    #1;
    check("mid reset row_valid", row_valid, 0);
    check("mid reset row_out", row_out, 0);
    check("mid reset rows_loaded", rows_loaded, 0);
    check("mid reset load_process", load_process, 0);
    check("mid reset row_ready", host_row_ready, 0);
    send = 0;
    @(negedge clk) rst = 1;
    tick();
    check("post reset row_ready", host_row_ready, 0);
    check("post reset row_valid", row_valid, 0);
    start = 1; tick(); start = 0;
    send = 1; tick();
    check("post reset fifo empty", row_valid, 0);
    send = 0; host_row_valid = 1; host_row = 8'h55; tick();
    host_row_valid = 0; tick();
    check("post reset pending row_valid", row_valid, 1);
    check("post reset pending row_out", row_out, 8'h55);
    $display("mid-load reset sequence done");

    // ---------------- pending timeout ----------------
    do_reset();
    start = 1; tick(); start = 0;
    send = 1; tick(); send = 0;
    irq_cnt = 0;
    for (int c = 0; c < 300; c++) begin
      tick();
      if (irq === 1'b1) irq_cnt++;
    end
    check("timeout irq pulses", irq_cnt, IRQ_EN ? 1 : 0);
    check("timeout no row", row_valid, 0);
    $display("pending timeout: %0d irq pulses", irq_cnt);

    // ---------------- randomized against model ----------------
    do_reset();
    model_reset();
    for (int c = 0; c < 600; c++) begin
      start = ($urandom_range(0, 7) == 0);
      host_row_valid = $urandom_range(0, 1);
      host_row = 8'($urandom);
      send = $urandom_range(0, 1);
      stop = ($urandom_range(0, 3) == 0);
      host_data_valid = $urandom_range(0, 1);
      host_data = 8'($urandom);
      host_data_last = ($urandom_range(0, 3) == 0);
      #1;
      model_step();
      check($sformatf("r%0d row_ready", c), host_row_ready, m_rr);
      check($sformatf("r%0d data_ready", c), host_data_ready, m_dr);
      tick();
      check($sformatf("r%0d row_valid", c), row_valid, m_rvld);
      check($sformatf("r%0d row_out", c), row_out, m_rout);
      check($sformatf("r%0d rows_loaded", c), rows_loaded, m_rl);
      check($sformatf("r%0d cnn_valid", c), cnn_data_valid, m_cv);
      check($sformatf("r%0d cnn_data", c), cnn_data, m_cd);
      check($sformatf("r%0d cnn_image", c), cnn_image, m_ci);
      check($sformatf("r%0d load_process", c), load_process, m_lp);
      check($sformatf("r%0d done", c), done, m_dn);
      check($sformatf("r%0d irq", c), irq, m_irq);
    end
    idle_inputs();
    $display("random: %0d cycles applied", 600);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
